// File: rtl/aq_gemac_erx_reader.sv
// rtl/aq_gemac_erx_reader.sv - drains ERX buffer frames into a byte stream with filtering
module aq_gemac_erx_reader #(
  parameter logic [15:0] MIN_LEN  = 16'd14,
  parameter logic [15:0] MAX_LEN  = 16'd1518,
  parameter bit          DROP_ERR = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        ERX_BUFF_RE,
  input  logic [31:0] ERX_BUFF_DATA,
  input  logic        ERX_BUFF_EMPTY,
  input  logic        ERX_BUFF_VALID,
  input  logic [15:0] ERX_BUFF_LENGTH,
  input  logic [15:0] ERX_BUFF_STATUS,
  output logic [7:0]  OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        OUT_SOF,
  output logic        OUT_EOF,
  output logic        OUT_ERR,
  output logic [15:0] OUT_STATUS,
  output logic [15:0] FRAME_CNT,
  output logic [15:0] DROP_CNT
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HEAD    = 3'd1;
  localparam logic [2:0] S_RD      = 3'd2;
  localparam logic [2:0] S_WT      = 3'd3;
  localparam logic [2:0] S_EMIT    = 3'd4;
  localparam logic [2:0] S_DROP_RD = 3'd5;
  localparam logic [2:0] S_DROP_WT = 3'd6;

  logic [2:0]  state;
  logic [14:0] word_cnt;   // words still to pop for the current frame
  logic [1:0]  len_lo;     // LENGTH[1:0], sizes the final word
  logic [31:0] shreg;
  logic [1:0]  idx;
  logic        first;      // next handshake is the frame's first byte

  logic [16:0] len_plus3;
  logic [14:0] words;
  logic        drop_frame;
  logic        last_word;
  logic [1:0]  last_idx;
  logic        byte_last;

  // Head-of-frame decode: word count and filter decision from the live header
  always_comb begin
    len_plus3  = {1'b0, ERX_BUFF_LENGTH} + 17'd3;
    words      = (ERX_BUFF_LENGTH == 16'd0) ? 15'd1 : len_plus3[16:2];
    drop_frame = (ERX_BUFF_LENGTH < MIN_LEN) || (ERX_BUFF_LENGTH > MAX_LEN) ||
                 (DROP_ERR && ERX_BUFF_STATUS[15]);
  end

  // Byte position within the word; the final word may be partial
  always_comb begin
    last_word = (word_cnt == 15'd0);
    last_idx  = (last_word && len_lo != 2'd0) ? len_lo - 2'd1 : 2'd3;
    byte_last = (idx == last_idx);
  end

  // Output stream decode; everything is a function of held state so it is stable under stall
  always_comb begin
    OUT_VALID   = (state == S_EMIT);
    ERX_BUFF_RE = (state == S_RD) || (state == S_DROP_RD);
    OUT_SOF     = OUT_VALID && first;
    OUT_EOF     = OUT_VALID && last_word && byte_last;
    OUT_ERR     = OUT_STATUS[15] && OUT_EOF;
    OUT_DATA    = 8'h00;
    if (OUT_VALID) begin
      case (idx)
        2'd0:    OUT_DATA = shreg[7:0];
        2'd1:    OUT_DATA = shreg[15:8];
        2'd2:    OUT_DATA = shreg[23:16];
        default: OUT_DATA = shreg[31:24];
      endcase
    end
  end

  // Frame sequencer: header latch, word pops, byte emission, drop draining, counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      word_cnt   <= 15'd0;
      len_lo     <= 2'd0;
      shreg      <= 32'd0;
      idx        <= 2'd0;
      first      <= 1'b0;
      OUT_STATUS <= 16'd0;
      FRAME_CNT  <= 16'd0;
      DROP_CNT   <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!ERX_BUFF_EMPTY) state <= S_HEAD;
        end
        S_HEAD: begin
          len_lo     <= ERX_BUFF_LENGTH[1:0];
          OUT_STATUS <= ERX_BUFF_STATUS;
          word_cnt   <= words;
          first      <= 1'b1;
          state      <= drop_frame ? S_DROP_RD : S_RD;
        end
        S_RD: begin
          word_cnt <= word_cnt - 15'd1;
          state    <= S_WT;
        end
        S_WT: begin
          if (ERX_BUFF_VALID) begin
            shreg <= ERX_BUFF_DATA;
            idx   <= 2'd0;
            state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (OUT_READY) begin
            first <= 1'b0;
            if (byte_last) begin
              if (last_word) begin
                FRAME_CNT <= FRAME_CNT + 16'd1;
                state     <= S_IDLE;
              end else begin
                state <= S_RD;
              end
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        S_DROP_RD: begin
          word_cnt <= word_cnt - 15'd1;
          state    <= S_DROP_WT;
        end
        S_DROP_WT: begin
          if (ERX_BUFF_VALID) begin
            if (word_cnt == 15'd0) begin
              DROP_CNT <= DROP_CNT + 16'd1;
              state    <= S_IDLE;
            end else begin
              state <= S_DROP_RD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
